// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game datapath input conditioning.
//   rep_state_t        : per-button hold-to-repeat state (IDLE/DELAY/REPEAT)
//   BTN_UP..BTN_RIGHT  : bit positions of the four directional buttons
//   DEF_*              : default debounce / repeat timing in clk cycles
//   maxInt()           : helper used to size counters shared by two limits
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  // The repeat counter serves both the initial delay and the period, so it
  // has to be wide enough for whichever of the two is larger.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One conditioned button: 2-FF synchroniser, debounce counter and the
// hold-to-repeat FSM.
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   btn_raw_i  : asynchronous raw button, active-high
//   db_o       : registered debounced level
//   db_next_o  : value db_o takes at the next edge (lets the parent register
//                derived flags with no extra latency)
//   press_o    : one-cycle pulse in the first cycle db_o is 1
//   strobe_o   : one-cycle raw move strobe (press plus auto-repeat)
// ---------------------------------------------------------------------------
module button_channel
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic db_o,
  output logic db_next_o,
  output logic press_o,
  output logic strobe_o
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX   = maxInt(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RCNT_W = (RMAX > 2) ? $clog2(RMAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PER_LAST   = RCNT_W'(REPEAT_PERIOD - 1);

  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic              strobe_q;
  rep_state_t        state_q;

  // Two flops bring the asynchronous pin into the clk domain before anything
  // else looks at it; the first stage may go metastable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the counter only advances while the synchronised input
  // disagrees with the accepted level, and any agreement restarts it, so the
  // level flips only after an unbroken run of disagreeing cycles.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The press pulse is registered from the same next-state value as the
  // debounced level, so both appear together in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= db_d & ~db_q;
    end
  end

  // Repeat FSM. It watches the next debounced level rather than the current
  // one: that puts the first strobe in the same cycle as the level rise, and
  // lets a release that lands on a terminal count cancel the strobe instead
  // of emitting one in the cycle the level has already dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rcnt_q <= '0;
          if (db_d && !db_q) begin
            strobe_q <= 1'b1;
            state_q  <= DELAY;
          end
        end
        DELAY: begin
          if (!db_d) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
          end else if (rcnt_q == DELAY_LAST) begin
            strobe_q <= 1'b1;
            rcnt_q   <= '0;
            state_q  <= REPEAT;
          end else begin
            rcnt_q <= rcnt_q + RCNT_W'(1);
          end
        end
        REPEAT: begin
          if (!db_d) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
          end else if (rcnt_q == PER_LAST) begin
            strobe_q <= 1'b1;
            rcnt_q   <= '0;
          end else begin
            rcnt_q <= rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          rcnt_q  <= '0;
        end
      endcase
    end
  end

  assign db_o      = db_q;
  assign db_next_o = db_d;
  assign press_o   = press_q;
  assign strobe_o  = strobe_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions the four directional buttons for the block movement controller.
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   btn_raw   : raw buttons [0]=up [1]=down [2]=left [3]=right, async
//   db_level  : debounced button levels
//   press     : one-cycle pulse on each debounced rise
//   move      : move strobes (press + auto-repeat) with opposing pairs masked
//   any_held  : registered OR of the debounced levels
// ---------------------------------------------------------------------------
module button_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] db_level,
  output logic [3:0] press,
  output logic [3:0] move,
  output logic       any_held
);

  logic [3:0] dbNext;
  logic [3:0] strobe;
  logic       anyHeld_q;

  for (genvar i = 0; i < 4; i++) begin : gChan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) uChan (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_raw[i]),
      .db_o     (db_level[i]),
      .db_next_o(dbNext[i]),
      .press_o  (press[i]),
      .strobe_o (strobe[i])
    );
  end

  // Opposing directions cancel: while both buttons of a pair are debounced
  // neither moves. The channel FSMs keep counting underneath, so releasing
  // one button resumes the other on its original repeat phase.
  always_comb begin
    move = strobe;
    if (db_level[BTN_UP] && db_level[BTN_DOWN]) begin
      move[BTN_UP]   = 1'b0;
      move[BTN_DOWN] = 1'b0;
    end
    if (db_level[BTN_LEFT] && db_level[BTN_RIGHT]) begin
      move[BTN_LEFT]  = 1'b0;
      move[BTN_RIGHT] = 1'b0;
    end
  end

  // any_held is registered from the channels' next debounced levels so it
  // changes in exactly the same cycle as db_level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anyHeld_q <= 1'b0;
    end else begin
      anyHeld_q <= |dbNext;
    end
  end

  assign any_held = anyHeld_q;

endmodule
